// File: rtl/rvc_pkg.sv
// Shared types and constants for the RVC fetch aligner: buffer occupancy states,
// halfword geometry and the opcode quadrant that marks a 32-bit instruction.
package rvc_pkg;

  localparam int         HW_W      = 16;
  localparam int         BUF_SLOTS = 3;
  localparam logic [1:0] QUAD_32   = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  function automatic logic is_cmpr(input logic [HW_W-1:0] hw);
    return hw[1:0] != QUAD_32;
  endfunction

endpackage

// File: rtl/rvc_fetch_align.sv
// Fetch aligner: turns 32-bit fetch words into 16/32-bit instructions with PCs.
// Define RVC_ALIGN_EN for compressed support; otherwise every word is one 32-bit instruction.
module rvc_fetch_align
  import rvc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_cmpr,
  output logic        ins_zero
);

`ifdef RVC_ALIGN_EN
  state_e          state_q, state_d;
  logic [HW_W-1:0] hw_q [BUF_SLOTS];
  logic [HW_W-1:0] hw_d [BUF_SLOTS];
  logic [HW_W-1:0] hw_s [BUF_SLOTS];
  logic [31:0]     pc_q, pc_d;
  logic            drop_lo_q, drop_lo_d;
  logic [1:0]      cnt, cnt_s, cnt_n;
  logic            hw0_cmpr, fire, accept;

  assign cnt         = state_q;
  assign hw0_cmpr    = is_cmpr(hw_q[0]);
  assign ins_valid   = !redirect && ((cnt != 2'd0 && hw0_cmpr) || cnt >= 2'd2);
  assign fetch_ready = (cnt <= 2'd1) && !redirect;
  assign fire        = ins_valid && ins_ready;
  assign accept      = fetch_valid && fetch_ready;

  // Slots above cnt are always zero, so an empty or partial buffer presents zeros.
  assign ins      = hw0_cmpr ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign ins_pc   = pc_q;
  assign ins_cmpr = (cnt != 2'd0) && hw0_cmpr;
  assign ins_zero = (hw_q[0] == '0);

  always_comb begin
    hw_s  = hw_q;
    cnt_s = cnt;
    if (fire) begin
      if (hw0_cmpr) begin
        hw_s[0] = hw_q[1];
        hw_s[1] = hw_q[2];
        hw_s[2] = '0;
        cnt_s   = cnt - 2'd1;
      end else begin
        hw_s[0] = hw_q[2];
        hw_s[1] = '0;
        hw_s[2] = '0;
        cnt_s   = cnt - 2'd2;
      end
    end
  end

  // Append lands after the post-consume contents; fetch_ready guarantees cnt_s <= 1.
  always_comb begin
    hw_d      = hw_s;
    cnt_n     = cnt_s;
    drop_lo_d = drop_lo_q;
    pc_d      = pc_q;
    if (fire) pc_d = pc_q + (hw0_cmpr ? 32'd2 : 32'd4);
    if (accept) begin
      if (drop_lo_q) begin
        for (int i = 0; i < BUF_SLOTS; i++)
          if (2'(i) == cnt_s) hw_d[i] = fetch_data[31:16];
        cnt_n     = cnt_s + 2'd1;
        drop_lo_d = 1'b0;
      end else begin
        for (int i = 0; i < BUF_SLOTS; i++) begin
          if (2'(i) == cnt_s)              hw_d[i] = fetch_data[15:0];
          else if (2'(i) == cnt_s + 2'd1)  hw_d[i] = fetch_data[31:16];
        end
        cnt_n = cnt_s + 2'd2;
      end
    end
    if (redirect) begin
      hw_d      = '{default: '0};
      cnt_n     = 2'd0;
      pc_d      = redirect_pc;
      drop_lo_d = redirect_pc[1];
    end
    state_d = state_e'(cnt_n);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      hw_q      <= '{default: '0};
      pc_q      <= '0;
      drop_lo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hw_q      <= hw_d;
      pc_q      <= pc_d;
      drop_lo_q <= drop_lo_d;
    end
  end

`else
  logic [31:0] word_q, word_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        fire, accept;
  logic        unused_pc_lo;

  // Word-aligned PCs only: the low redirect bits carry no information here.
  assign unused_pc_lo = ^redirect_pc[1:0];

  assign ins_valid   = valid_q && !redirect;
  assign fire        = ins_valid && ins_ready;
  assign fetch_ready = (!valid_q || fire) && !redirect;
  assign accept      = fetch_valid && fetch_ready;
  assign ins         = word_q;
  assign ins_pc      = pc_q;
  assign ins_cmpr    = 1'b0;
  assign ins_zero    = (word_q[15:0] == 16'h0);

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    if (fire) begin
      word_d  = '0;
      valid_d = 1'b0;
      pc_d    = pc_q + 32'd4;
    end
    if (accept) begin
      word_d  = fetch_data;
      valid_d = 1'b1;
    end
    if (redirect) begin
      word_d  = '0;
      valid_d = 1'b0;
      pc_d    = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_rvc_fetch_align.sv
// Self-checking bench for rvc_fetch_align: directed table, multi-cycle corner
// sequences and a randomized run against an instruction-stream reference model.
module tb_rvc_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n, fetch_valid, redirect, ins_ready;
  logic [31:0] fetch_data, redirect_pc;
  logic        fetch_ready, ins_valid, ins_cmpr, ins_zero;
  logic [31:0] ins, ins_pc;

  rvc_fetch_align dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
    .ins_cmpr(ins_cmpr), .ins_zero(ins_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_ins;
    logic [31:0] exp_pc;
    logic        exp_cmpr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] words_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] exp_pc_q[$];
  int          acc_cyc_q[$];
  int          out_cyc_q[$];
  logic [15:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Expected compressed flag of a presented instruction.
  function automatic logic exp_cmpr_of(input logic [31:0] i);
`ifdef RVC_ALIGN_EN
    return i[1:0] != 2'b11;
`else
    return 1'b0 & i[0];
`endif
  endfunction

  task automatic push_exp(input logic [31:0] i, input logic [31:0] pc);
    exp_ins_q.push_back(i);
    exp_pc_q.push_back(pc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; fetch_valid = 1'b0; ins_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = pc; fetch_valid = 1'b0;
    @(posedge clk);
    #1 redirect = 1'b0;
  endtask

  task automatic feed_one(input string name, input logic [31:0] w);
    int  n = 0;
    bit  done = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      fetch_valid = 1'b1; fetch_data = w;
      #1 done = fetch_ready;
      n++;
    end
    if (!done) fail(name, "word never accepted within 8 cycles");
    @(negedge clk);
    fetch_valid = 1'b0;
  endtask

  // Streams words_q with ins_ready high, checks each presented instruction in order.
  task automatic run_stream(input string name, input int max_cyc);
    int n = 0;
    acc_cyc_q.delete();
    out_cyc_q.delete();
    while (exp_ins_q.size() > 0 && n < max_cyc) begin
      @(negedge clk);
      redirect    = 1'b0;
      ins_ready   = 1'b1;
      fetch_valid = (words_q.size() > 0);
      fetch_data  = fetch_valid ? words_q[0] : 32'h0;
      #1;
      if (ins_valid) begin
        $display("%s: ins=0x%08h pc=0x%08h cmpr=%0b", name, ins, ins_pc, ins_cmpr);
        chk({name, " ins"}, ins, exp_ins_q[0]);
        chk({name, " pc"}, ins_pc, exp_pc_q[0]);
        chk({name, " cmpr"}, ins_cmpr, exp_cmpr_of(exp_ins_q[0]));
        chk({name, " zero"}, ins_zero, exp_ins_q[0][15:0] == 16'h0);
        void'(exp_ins_q.pop_front());
        void'(exp_pc_q.pop_front());
        out_cyc_q.push_back(cyc);
      end
      if (fetch_valid && fetch_ready) begin
        void'(words_q.pop_front());
        acc_cyc_q.push_back(cyc);
      end
      n++;
    end
    if (exp_ins_q.size() > 0) begin
      fail(name, $sformatf("timeout with %0d instructions outstanding", exp_ins_q.size()));
      exp_ins_q.delete();
      exp_pc_q.delete();
    end
    words_q.delete();
    @(negedge clk);
    fetch_valid = 1'b0;
    ins_ready   = 1'b0;
  endtask

  task automatic check_latency(input string name, input int k);
    if (acc_cyc_q.size() > k && out_cyc_q.size() > k)
      chk(name, out_cyc_q[k], acc_cyc_q[k] + 1);
    else
      fail(name, "missing accept/output events");
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    int n = 0;
    do_reset();
    do_redirect(v.start_pc);
    words_q.delete();
    words_q.push_back(v.w0);
    words_q.push_back(v.w1);
    @(negedge clk);
    while (words_q.size() > 0 && n < 6) begin
      fetch_valid = 1'b1; fetch_data = words_q[0];
      #1 if (fetch_ready) void'(words_q.pop_front());
      n++;
      @(negedge clk);
    end
    fetch_valid = 1'b0;
    words_q.delete();
    #1;
    $display("vec%0d: ins=0x%08h pc=0x%08h cmpr=%0b zero=%0b", k, ins, ins_pc, ins_cmpr, ins_zero);
    chk($sformatf("vec%0d valid", k), ins_valid, 1'b1);
    chk($sformatf("vec%0d ins", k), ins, v.exp_ins);
    chk($sformatf("vec%0d pc", k), ins_pc, v.exp_pc);
    chk($sformatf("vec%0d cmpr", k), ins_cmpr, v.exp_cmpr);
    chk($sformatf("vec%0d zero", k), ins_zero, v.exp_ins[15:0] == 16'h0);
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 1) & 32'hff);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i = midx(a);
    return {mem[(i + 1) % 256], mem[i]};
  endfunction

  task automatic check_post_reset(input string name);
    chk({name, " ins_valid"}, ins_valid, 1'b0);
    chk({name, " ins"}, ins, 32'h0);
    chk({name, " ins_cmpr"}, ins_cmpr, 1'b0);
    chk({name, " ins_zero"}, ins_zero, 1'b1);
    chk({name, " fetch_ready"}, fetch_ready, 1'b1);
  endtask

  task automatic random_run(input int n_cyc);
    logic [31:0] m_pc = 0, f_addr = 0, e_ins;
    logic [15:0] hw;
    int e_len, idle = 0, n_fired = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
    end
    do_reset();
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = 32'($urandom_range(0, 255)) << 1;
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_data  = word_at(f_addr);
      ins_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (redirect) begin
        chk("rnd redirect ins_valid", ins_valid, 1'b0);
`ifdef RVC_ALIGN_EN
        chk("rnd redirect fetch_ready", fetch_ready, 1'b0);
        m_pc = redirect_pc;
`else
        m_pc = redirect_pc & ~32'h3;
`endif
        f_addr = redirect_pc & ~32'h3;
        idle   = 0;
      end else begin
        if (ins_valid) begin
`ifdef RVC_ALIGN_EN
          hw = mem[midx(m_pc)];
          if (hw[1:0] != 2'b11) begin e_ins = {16'h0, hw}; e_len = 2; end
          else begin e_ins = {mem[(midx(m_pc) + 1) % 256], hw}; e_len = 4; end
`else
          e_ins = word_at(m_pc); e_len = 4;
`endif
          chk("rnd ins", ins, e_ins);
          chk("rnd pc", ins_pc, m_pc);
          chk("rnd cmpr", ins_cmpr, exp_cmpr_of(e_ins));
          chk("rnd zero", ins_zero, e_ins[15:0] == 16'h0);
          if (ins_ready) begin
            m_pc = m_pc + 32'(e_len);
            n_fired++;
          end
          idle = 0;
        end else begin
          idle++;
        end
        if (fetch_valid && fetch_ready) f_addr = f_addr + 32'd4;
        if (idle > 40) begin
          fail("rnd liveness", $sformatf("no instruction for 40 cycles at pc 0x%08h", m_pc));
          break;
        end
      end
    end
    $display("random run: %0d instructions consumed", n_fired);
    if (n_fired < 100) fail("rnd progress", $sformatf("only %0d instructions consumed", n_fired));
    redirect = 1'b0; fetch_valid = 1'b0; ins_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;

`ifdef RVC_ALIGN_EN
    vecs.push_back(vec_t'{32'h0,        32'h0001_0001, 32'h0,         32'h0000_0001, 32'h0,        1'b1});
    vecs.push_back(vec_t'{32'h0,        32'h0001_0513, 32'h0,         32'h0001_0513, 32'h0,        1'b0});
    vecs.push_back(vec_t'{32'h102,      32'h4505_0000, 32'h0,         32'h0000_4505, 32'h102,      1'b1});
    vecs.push_back(vec_t'{32'h102,      32'h0513_ffff, 32'h0000_0001, 32'h0001_0513, 32'h102,      1'b0});
    vecs.push_back(vec_t'{32'h0,        32'h0000_0000, 32'h0,         32'h0000_0000, 32'h0,        1'b1});
    vecs.push_back(vec_t'{32'hFFFFFFFC, 32'h1234_5677, 32'h0,         32'h1234_5677, 32'hFFFFFFFC, 1'b0});
`else
    vecs.push_back(vec_t'{32'h0,        32'h0000_0013, 32'h0,         32'h0000_0013, 32'h0,        1'b0});
    vecs.push_back(vec_t'{32'h102,      32'h0001_0001, 32'h0,         32'h0001_0001, 32'h100,      1'b0});
    vecs.push_back(vec_t'{32'h200,      32'habcd_0000, 32'h0,         32'habcd_0000, 32'h200,      1'b0});
    vecs.push_back(vec_t'{32'hFFFFFFFC, 32'h1234_5677, 32'h0,         32'h1234_5677, 32'hFFFFFFFC, 1'b0});
`endif

    // Reset state, held in reset and after release.
    repeat (2) @(negedge clk);
    #1;
    chk("in reset ins_valid", ins_valid, 1'b0);
    chk("in reset ins_zero", ins_zero, 1'b1);
    chk("in reset ins_cmpr", ins_cmpr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_post_reset("after reset");

    foreach (vecs[k]) apply_vec(vecs[k], k);

`ifdef RVC_ALIGN_EN
    // Two C.NOPs in one word.
    do_reset();
    words_q.push_back(32'h0001_0001);
    push_exp(32'h1, 32'h0); push_exp(32'h1, 32'h2);
    run_stream("cnop pair", 20);
    check_latency("cnop latency", 0);

    // 32-bit then two compressed.
    do_reset();
    words_q.push_back(32'h0001_0513); words_q.push_back(32'h4505_0000);
    push_exp(32'h0001_0513, 32'h0); push_exp(32'h0, 32'h4); push_exp(32'h4505, 32'h6);
    run_stream("mixed", 20);

    // 32-bit instruction straddling a word boundary.
    do_reset();
    words_q.push_back(32'h0513_0001); words_q.push_back(32'h0000_0001);
    push_exp(32'h1, 32'h0); push_exp(32'h0001_0513, 32'h2);
    run_stream("straddle", 20);
    check_latency("straddle latency", 1);

    // Full buffer with decode stalled: nothing accepted, nothing lost.
    do_reset();
    do_redirect(32'h2);
    feed_one("stall w0", 32'h0001_ffff);
    feed_one("stall w1", 32'h0005_0009);
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1; fetch_data = 32'h000d_0011;
      #1;
      chk($sformatf("stall%0d fetch_ready", i), fetch_ready, 1'b0);
      chk($sformatf("stall%0d ins", i), ins, 32'h1);
      chk($sformatf("stall%0d pc", i), ins_pc, 32'h2);
      @(negedge clk);
    end
    words_q.push_back(32'h000d_0011);
    push_exp(32'h1, 32'h2); push_exp(32'h9, 32'h4); push_exp(32'h5, 32'h6);
    push_exp(32'h11, 32'h8); push_exp(32'hd, 32'ha);
    run_stream("stall drain", 30);
`else
    do_reset();
    words_q.push_back(32'h13); words_q.push_back(32'h13); words_q.push_back(32'h13);
    push_exp(32'h13, 32'h0); push_exp(32'h13, 32'h4); push_exp(32'h13, 32'h8);
    run_stream("addi x3", 20);
    check_latency("addi latency", 0);

    do_reset();
    feed_one("stall w0", 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1; fetch_data = 32'h0010_0093;
      #1;
      chk($sformatf("stall%0d fetch_ready", i), fetch_ready, 1'b0);
      chk($sformatf("stall%0d ins", i), ins, 32'h13);
      chk($sformatf("stall%0d pc", i), ins_pc, 32'h0);
      @(negedge clk);
    end
    words_q.push_back(32'h0010_0093);
    push_exp(32'h13, 32'h0); push_exp(32'h0010_0093, 32'h4);
    run_stream("stall drain", 20);
`endif

    // Redirect with a word in flight and a non-empty buffer.
    do_reset();
    feed_one("redir fill", 32'h0001_0001);
    redirect = 1'b1; redirect_pc = 32'h102; fetch_valid = 1'b1; fetch_data = 32'hdead_beef;
    #1;
    chk("redir ins_valid", ins_valid, 1'b0);
`ifdef RVC_ALIGN_EN
    chk("redir fetch_ready", fetch_ready, 1'b0);
`endif
    @(posedge clk);
    #1 redirect = 1'b0; fetch_valid = 1'b0;
    words_q.push_back(32'h4505_0001);
`ifdef RVC_ALIGN_EN
    push_exp(32'h4505, 32'h102);
`else
    push_exp(32'h4505_0001, 32'h100);
`endif
    run_stream("redir", 20);

    // Reset while instructions are buffered and decode is stalled; reset beats redirect.
    do_reset();
    feed_one("rst fill", 32'h0001_0001);
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h50;
    fetch_valid = 1'b1; fetch_data = 32'h0003_0003;
    @(negedge clk);
    rst_n = 1'b1; redirect = 1'b0; fetch_valid = 1'b0;
    #1 check_post_reset("mid reset");
    words_q.push_back(32'h0001_0001);
`ifdef RVC_ALIGN_EN
    push_exp(32'h1, 32'h0); push_exp(32'h1, 32'h2);
`else
    push_exp(32'h0001_0001, 32'h0);
`endif
    run_stream("post reset", 20);

    random_run(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
